// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and data access.
// Data requests win over fetches; completions are reported with registered one-cycle ready pulses.
module mem_port_arbiter #(
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic [3:0] WaitCnt = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        discard_q, discard_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        dm_ready_q, dm_ready_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      discard_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      if_ready_q  <= 1'b0;
      dm_rdata_q  <= 32'd0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      discard_q   <= discard_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    discard_d   = discard_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_ready_d  = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    dm_ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dm_read || dm_write) begin
          state_d     = BUSY_D;
          owner_d     = 1'b1;
          discard_d   = 1'b0;
          cnt_d       = WaitCnt;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d    = BUSY_I;
          owner_d    = 1'b0;
          discard_d  = 1'b0;
          cnt_d      = WaitCnt;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end

      // A fetch withdrawn at any point, including the capture cycle, suppresses its ready pulse.
      BUSY_D, BUSY_I: begin
        cnt_d = cnt_q - 4'd1;
        if (!owner_q && !if_req) begin
          discard_d = 1'b1;
        end
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (owner_q) begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ready_d = !discard_q && if_req;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;

  assign stall_if  = if_req && !if_ready_q;
  assign stall_mem = (dm_read || dm_write) && !dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a WAIT=2 instance with a word-array memory model
// and a WAIT=15 instance with an address-derived memory model for back-to-back fetches.
module tb_mem_port_arbiter;

  localparam int WAIT2  = 2;
  localparam int WAIT15 = 15;

  logic        clk;
  logic        reset;
  int          checks;
  int          failures;

  logic        ifReq, dmRead, dmWrite;
  logic [31:0] ifAddr, dmAddr, dmWdata, memRdata;
  logic [31:0] ifRdata, dmRdata, memAddr, memWdata;
  logic        ifReady, dmReady, memEn, memWe, stallIf, stallMem;

  logic        ifReq15, zeroBit;
  logic [31:0] ifAddr15, zeroWord, memRdata15;
  logic [31:0] ifRdata15, dmRdata15, memAddr15, memWdata15;
  logic        ifReady15, dmReady15, memEn15, memWe15, stallIf15, stallMem15;

  mem_port_arbiter #(.WAIT(WAIT2)) dut (
    .clk(clk), .reset(reset),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ready(ifReady),
    .dm_read(dmRead), .dm_write(dmWrite), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_rdata(dmRdata), .dm_ready(dmReady),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .stall_if(stallIf), .stall_mem(stallMem)
  );

  mem_port_arbiter #(.WAIT(WAIT15)) dut15 (
    .clk(clk), .reset(reset),
    .if_req(ifReq15), .if_addr(ifAddr15), .if_rdata(ifRdata15), .if_ready(ifReady15),
    .dm_read(zeroBit), .dm_write(zeroBit), .dm_addr(zeroWord), .dm_wdata(zeroWord),
    .dm_rdata(dmRdata15), .dm_ready(dmReady15),
    .mem_en(memEn15), .mem_we(memWe15), .mem_addr(memAddr15), .mem_wdata(memWdata15),
    .mem_rdata(memRdata15), .stall_if(stallIf15), .stall_mem(stallMem15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data is driven only in the cycle WAIT cycles into the access, poison otherwise.
  logic [31:0] memArr [0:255];
  bit          memInitDone;
  logic [7:0]  latIdx;
  int          rdLeft;
  always @(posedge clk) begin
    if (!memInitDone) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 32'h0;
      memArr[64] <= 32'h2002000A;
      memArr[65] <= 32'h11112222;
      memArr[66] <= 32'h33334444;
      memArr[16] <= 32'hDEADBEEF;
      memInitDone <= 1'b1;
    end else if (memEn && memWe) begin
      memArr[memAddr[9:2]] <= memWdata;
    end
    if (memEn && !memWe) begin
      rdLeft <= WAIT2 - 1;
      latIdx <= memAddr[9:2];
    end else if (rdLeft > 0) begin
      rdLeft <= rdLeft - 1;
    end
  end
  assign memRdata = (rdLeft == 1 && !memEn) ? memArr[latIdx] : 32'hBAD0BAD0;

  logic [31:0] latAddr15;
  int          rdLeft15;
  always @(posedge clk) begin
    if (memEn15 && !memWe15) begin
      rdLeft15  <= WAIT15 - 1;
      latAddr15 <= memAddr15;
    end else if (rdLeft15 > 0) begin
      rdLeft15 <= rdLeft15 - 1;
    end
  end
  assign memRdata15 = (rdLeft15 == 1 && !memEn15) ? (latAddr15 ^ 32'hA5A50000) : 32'hBAD0BAD0;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) nextCycle();
    midCycle();
    checks++; if (memEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_en: got %b want 0", memEn); end
    checks++; if (memWe !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_we: got %b want 0", memWe); end
    checks++; if (memAddr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h want 0", memAddr); end
    checks++; if (memWdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", memWdata); end
    checks++; if (ifRdata !== 32'h0 || dmRdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h/%h want 0/0", ifRdata, dmRdata); end
    checks++; if (ifReady !== 1'b0 || dmReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b/%b want 0/0", ifReady, dmReady); end
    checks++; if (stallIf !== 1'b0 || stallMem !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b/%b want 0/0", stallIf, stallMem); end
    nextCycle();
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    nextCycle(); ifReq = 1'b1; ifAddr = 32'h100;
    midCycle();
    checks++; if (stallIf !== 1'b1) begin failures++; $display("[TB] FAIL fetch_stall_c0: got %b want 1", stallIf); end
    checks++; if (memEn !== 1'b0) begin failures++; $display("[TB] FAIL fetch_mem_en_c0: got %b want 0", memEn); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1) begin failures++; $display("[TB] FAIL fetch_mem_en_c1: got %b want 1", memEn); end
    checks++; if (memAddr !== 32'h100 || memWe !== 1'b0) begin failures++; $display("[TB] FAIL fetch_addr_c1: got %h we=%b want 100 we=0", memAddr, memWe); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b0 || ifReady !== 1'b0 || stallIf !== 1'b1) begin failures++; $display("[TB] FAIL fetch_c2: got en=%b rdy=%b stall=%b want 0/0/1", memEn, ifReady, stallIf); end
    nextCycle(); midCycle();
    checks++; if (ifReady !== 1'b1) begin failures++; $display("[TB] FAIL fetch_ready_c3: got %b want 1", ifReady); end
    checks++; if (ifRdata !== 32'h2002000A) begin failures++; $display("[TB] FAIL fetch_rdata_c3: got %h want 2002000a", ifRdata); end
    checks++; if (stallIf !== 1'b0) begin failures++; $display("[TB] FAIL fetch_stall_c3: got %b want 0", stallIf); end
    nextCycle(); ifReq = 1'b0;
    midCycle();
    checks++; if (ifReady !== 1'b0 || ifRdata !== 32'h2002000A) begin failures++; $display("[TB] FAIL fetch_hold_c4: got rdy=%b data=%h want 0/2002000a", ifReady, ifRdata); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b0) begin failures++; $display("[TB] FAIL fetch_no_regrant_c5: got %b want 0", memEn); end
  endtask

  task automatic test_priority();
    nextCycle(); dmRead = 1'b1; dmAddr = 32'h40; ifReq = 1'b1; ifAddr = 32'h104;
    midCycle();
    checks++; if (stallMem !== 1'b1 || stallIf !== 1'b1) begin failures++; $display("[TB] FAIL prio_stall_c0: got %b/%b want 1/1", stallMem, stallIf); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1 || memAddr !== 32'h40 || memWe !== 1'b0) begin failures++; $display("[TB] FAIL prio_data_grant_c1: got en=%b addr=%h we=%b want 1/40/0", memEn, memAddr, memWe); end
    nextCycle(); nextCycle(); midCycle();
    checks++; if (dmReady !== 1'b1 || dmRdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL prio_dm_ready_c3: got rdy=%b data=%h want 1/deadbeef", dmReady, dmRdata); end
    checks++; if (ifReady !== 1'b0 || stallMem !== 1'b0 || stallIf !== 1'b1) begin failures++; $display("[TB] FAIL prio_c3_side: got ifrdy=%b smem=%b sif=%b want 0/0/1", ifReady, stallMem, stallIf); end
    nextCycle(); dmRead = 1'b0;
    midCycle();
    checks++; if (memEn !== 1'b0 || dmReady !== 1'b0) begin failures++; $display("[TB] FAIL prio_idle_c4: got en=%b rdy=%b want 0/0", memEn, dmReady); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1 || memAddr !== 32'h104) begin failures++; $display("[TB] FAIL prio_fetch_grant_c5: got en=%b addr=%h want 1/104", memEn, memAddr); end
    nextCycle(); nextCycle(); midCycle();
    checks++; if (ifReady !== 1'b1 || ifRdata !== 32'h11112222) begin failures++; $display("[TB] FAIL prio_if_ready_c7: got rdy=%b data=%h want 1/11112222", ifReady, ifRdata); end
    checks++; if (dmReady !== 1'b0) begin failures++; $display("[TB] FAIL prio_dm_once_c7: got %b want 0", dmReady); end
    nextCycle(); ifReq = 1'b0;
  endtask

  task automatic test_store();
    nextCycle(); dmWrite = 1'b1; dmAddr = 32'h80; dmWdata = 32'h12345678;
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1 || memWe !== 1'b1) begin failures++; $display("[TB] FAIL store_en_we_c1: got %b/%b want 1/1", memEn, memWe); end
    checks++; if (memAddr !== 32'h80 || memWdata !== 32'h12345678) begin failures++; $display("[TB] FAIL store_latch_c1: got %h/%h want 80/12345678", memAddr, memWdata); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b0 || memWe !== 1'b1 || memAddr !== 32'h80) begin failures++; $display("[TB] FAIL store_hold_c2: got en=%b we=%b addr=%h want 0/1/80", memEn, memWe, memAddr); end
    nextCycle(); midCycle();
    checks++; if (dmReady !== 1'b1 || dmRdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL store_ready_c3: got rdy=%b data=%h want 1/deadbeef", dmReady, dmRdata); end
    nextCycle(); dmWrite = 1'b0; dmRead = 1'b1; dmWdata = 32'h0;
    midCycle();
    checks++; if (dmReady !== 1'b0) begin failures++; $display("[TB] FAIL store_ready_pulse_c4: got %b want 0", dmReady); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h80) begin failures++; $display("[TB] FAIL reload_grant_c5: got en=%b we=%b addr=%h want 1/0/80", memEn, memWe, memAddr); end
    nextCycle(); nextCycle(); midCycle();
    checks++; if (dmReady !== 1'b1 || dmRdata !== 32'h12345678) begin failures++; $display("[TB] FAIL reload_data_c7: got rdy=%b data=%h want 1/12345678", dmReady, dmRdata); end
    nextCycle(); dmRead = 1'b0;
  endtask

  task automatic test_flush();
    nextCycle(); ifReq = 1'b1; ifAddr = 32'h108;
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1 || memAddr !== 32'h108) begin failures++; $display("[TB] FAIL flush_grant_c1: got en=%b addr=%h want 1/108", memEn, memAddr); end
    nextCycle(); ifReq = 1'b0;
    midCycle();
    checks++; if (stallIf !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall_c2: got %b want 0", stallIf); end
    nextCycle(); midCycle();
    checks++; if (ifReady !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_ready_c3: got %b want 0", ifReady); end
    checks++; if (ifRdata !== 32'h33334444) begin failures++; $display("[TB] FAIL flush_rdata_c3: got %h want 33334444", ifRdata); end
    nextCycle(); ifReq = 1'b1; ifAddr = 32'h100;
    midCycle();
    checks++; if (memEn !== 1'b0 || ifReady !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_c4: got en=%b rdy=%b want 0/0", memEn, ifReady); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1 || memAddr !== 32'h100) begin failures++; $display("[TB] FAIL flush_refetch_c5: got en=%b addr=%h want 1/100", memEn, memAddr); end
    nextCycle(); nextCycle(); midCycle();
    checks++; if (ifReady !== 1'b1 || ifRdata !== 32'h2002000A) begin failures++; $display("[TB] FAIL flush_refetch_c7: got rdy=%b data=%h want 1/2002000a", ifReady, ifRdata); end
    nextCycle(); ifReq = 1'b0;
  endtask

  task automatic test_reset_midload();
    nextCycle(); dmRead = 1'b1; dmAddr = 32'h40;
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1) begin failures++; $display("[TB] FAIL rstload_grant_c1: got %b want 1", memEn); end
    nextCycle(); reset = 1'b1;
    #1;
    checks++; if (memEn !== 1'b0 || memWe !== 1'b0 || memAddr !== 32'h0) begin failures++; $display("[TB] FAIL rstload_mem_c2: got en=%b we=%b addr=%h want 0/0/0", memEn, memWe, memAddr); end
    checks++; if (dmRdata !== 32'h0 || ifRdata !== 32'h0 || dmReady !== 1'b0) begin failures++; $display("[TB] FAIL rstload_out_c2: got %h/%h rdy=%b want 0/0/0", dmRdata, ifRdata, dmReady); end
    nextCycle(); midCycle();
    checks++; if (dmReady !== 1'b0 || memEn !== 1'b0) begin failures++; $display("[TB] FAIL rstload_quiet_c3: got rdy=%b en=%b want 0/0", dmReady, memEn); end
    nextCycle(); reset = 1'b0;
    midCycle();
    checks++; if (memEn !== 1'b0 || dmReady !== 1'b0) begin failures++; $display("[TB] FAIL rstload_idle_c4: got en=%b rdy=%b want 0/0", memEn, dmReady); end
    nextCycle(); midCycle();
    checks++; if (memEn !== 1'b1 || memAddr !== 32'h40) begin failures++; $display("[TB] FAIL rstload_regrant_c5: got en=%b addr=%h want 1/40", memEn, memAddr); end
    nextCycle(); nextCycle(); midCycle();
    checks++; if (dmReady !== 1'b1 || dmRdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rstload_done_c7: got rdy=%b data=%h want 1/deadbeef", dmReady, dmRdata); end
    nextCycle(); dmRead = 1'b0;
  endtask

  task automatic test_back_to_back();
    int  readyCount;
    bit  expReady, expEn;
    readyCount = 0;
    for (int c = 0; c < 60; c++) begin
      nextCycle();
      if (c == 0) begin
        ifReq15  = 1'b1;
        ifAddr15 = 32'h200;
      end
      midCycle();
      expReady = (c == 16) || (c == 33) || (c == 50);
      expEn    = (c == 1) || (c == 18) || (c == 35) || (c == 52);
      if (ifReady15 === 1'b1) readyCount++;
      checks++; if (ifReady15 !== expReady) begin failures++; $display("[TB] FAIL b2b_ready_c%0d: got %b want %b", c, ifReady15, expReady); end
      checks++; if (memEn15 !== expEn) begin failures++; $display("[TB] FAIL b2b_mem_en_c%0d: got %b want %b", c, memEn15, expEn); end
      if (expReady) begin
        checks++; if (ifRdata15 !== 32'hA5A50200) begin failures++; $display("[TB] FAIL b2b_rdata_c%0d: got %h want a5a50200", c, ifRdata15); end
      end
    end
    checks++; if (readyCount != 3) begin failures++; $display("[TB] FAIL b2b_ready_count: got %0d want 3", readyCount); end
    nextCycle(); ifReq15 = 1'b0;
    repeat (20) nextCycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ifReq = 1'b0; ifAddr = 32'h0;
    dmRead = 1'b0; dmWrite = 1'b0; dmAddr = 32'h0; dmWdata = 32'h0;
    ifReq15 = 1'b0; ifAddr15 = 32'h0;
    zeroBit = 1'b0; zeroWord = 32'h0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_flush();
    test_reset_midload();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage. Requests are level-held, and data accesses (load/store, from the decoder's MemRead/MemWrite) take priority over fetches. The block drives per-stage stall signals back to the pipeline and returns read data through registered one-cycle ready pulses.

## Interface
- WAIT, 2: memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_ready, may drop early on flush.
- if_addr  input  32  fetch address; stable while if_req is high.
- if_rdata  output  32  fetched instruction; valid while if_ready is high, held afterwards.
- if_ready  output  1  one-cycle fetch completion pulse.
- dm_read  input  1  load request (MemRead); held until dm_ready.
- dm_write  input  1  store request (MemWrite); held until dm_ready.
- dm_addr  input  32  data address.
- dm_wdata  input  32  store data.
- dm_rdata  output  32  load data; valid while dm_ready is high, held afterwards.
- dm_ready  output  1  one-cycle data completion pulse.
- mem_en  output  1  memory access strobe, one cycle per access.
- mem_we  output  1  write enable, qualified by mem_en.
- mem_addr  output  32  registered address.
- mem_wdata  output  32  registered write data.
- mem_rdata  input  32  memory read data, valid WAIT cycles after the mem_en cycle.
- stall_if  output  1  if_req && !if_ready.
- stall_mem  output  1  (dm_read || dm_write) && !dm_ready.

## Operation
- States: IDLE, BUSY_D, BUSY_I, DONE. The state register, a 4-bit wait counter cnt, an owner bit and a discard bit are all registered.
- IDLE, with dm_read or dm_write high: go to BUSY_D and latch mem_addr=dm_addr, mem_wdata=dm_wdata, mem_we=dm_write. A data request always wins over if_req.
- IDLE, with only if_req high: go to BUSY_I, latch mem_addr=if_addr, mem_we=0, discard=0.
- IDLE, with no request: stay in IDLE.
- Entry to BUSY_*: mem_en=1 for exactly the first BUSY cycle, and cnt loads WAIT. cnt decrements each cycle after that.
- At cnt==1 in BUSY_*, mem_rdata is valid:
  - Capture it into if_rdata (BUSY_I) or dm_rdata (BUSY_D load).
  - A store leaves dm_rdata unchanged.
  - Go to DONE.
- DONE: pulse ready for the owner (dm_ready for BUSY_D; if_ready for BUSY_I unless discard=1). Always return to IDLE. No grant is made in DONE, so a request that is still high for one cycle after its ready is never re-serviced.
- Flush: if if_req falls during BUSY_I, set discard=1. The access still completes, if_rdata is still updated, and if_ready is not pulsed.
- dm_read and dm_write both high is treated as a store.
- Data requests never withdraw; dropping one mid-access is a pipeline error and the access still completes.
- stall_if and stall_mem are combinational from the request inputs and the registered ready outputs.

## Timing
- Reset, asynchronous and immediate: state=IDLE, cnt=0, discard=0. mem_en, mem_we, mem_addr, mem_wdata, if_rdata, if_ready, dm_rdata and dm_ready are all 0. Any access in flight is abandoned with no ready pulse.
- Request seen in IDLE at cycle 0:
  - mem_en is high in cycle 1.
  - mem_rdata is sampled at the end of cycle WAIT.
  - ready is high in cycle WAIT+1.
  - IDLE again in cycle WAIT+2.
- Throughput: one access per WAIT+2 cycles per request stream.
- A fetch arriving while a data access is in progress waits for DONE plus one IDLE cycle. With continuous data requests, fetch is stalled by design.
- mem_addr, mem_we and mem_wdata hold stable from the mem_en cycle through DONE.

## Test plan
- Single fetch, WAIT=2, memory word at 0x100 = 0x2002000A: if_req with if_addr=0x100 in cycle 0 -> mem_en high in cycle 1, if_ready and if_rdata=0x2002000A in cycle 3, stall_if high in cycles 0..2.
- Simultaneous LW at 0x40 (memory value 0xDEADBEEF) and fetch at 0x104: data is served first -> dm_ready in cycle 3 with 0xDEADBEEF, fetch mem_en in cycle 5, if_ready in cycle 7.
- SW with dm_addr=0x80 and dm_wdata=0x12345678 -> one mem_en cycle with mem_we=1 and the latched values, dm_ready in cycle 3, dm_rdata unchanged. A following LW of 0x80 returns 0x12345678.
- Flush: drop if_req in cycle 2 of a fetch -> no if_ready pulse, state back in IDLE in cycle 4. A new fetch is then granted normally.
- Reset asserted in cycle 2 of a load -> all outputs 0 immediately and no dm_ready. After reset release, the held dm_read is re-granted from IDLE.
- WAIT=15 with back-to-back fetches held high -> if_ready every 17 cycles, no double service of any request.
